time_of_day_keeper: RTL and testbench
=====================================

TIME_OF_DAY_KEEPER -- requirements
Module: time_of_day_keeper

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 1: number of tick_in pulses per second advance, legal range 1..255.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port tick_in  input  1  single-cycle pulse from the upstream counter's rollover output.
REQ-005 SHALL have port run_en  input  1  1 = timekeeping runs, 0 = paused.
REQ-006 SHALL have port set_valid  input  1  time-load request.
REQ-007 SHALL have port set_hours  input  5  load value, hours.
REQ-008 SHALL have port set_minutes  input  6  load value, minutes.
REQ-009 SHALL have port set_seconds  input  6  load value, seconds.
REQ-010 SHALL have port set_ready  output  1  load accepted when set_valid & set_ready.
REQ-011 SHALL have port set_error  output  1  one-cycle pulse on rejected load.
REQ-012 SHALL have port hours  output  5  current hours, binary 0..23.
REQ-013 SHALL have port minutes  output  6  current minutes, binary 0..59.
REQ-014 SHALL have port seconds  output  6  current seconds, binary 0..59.
REQ-015 SHALL have port sec_pulse  output  1  one-cycle pulse on every seconds advance.
REQ-016 SHALL have port day_rollover  output  1  one-cycle pulse on 23:59:59 -> 00:00:00.
REQ-017 SHALL have ports alarm_arm (input, 1), alarm_hours (input, 5), alarm_minutes (input, 6), alarm_hit (output, 1, one-cycle pulse).

Function
REQ-018 SHALL implement two states, PAUSED and RUN; registered state advances PAUSED->RUN on an edge with run_en=1 and RUN->PAUSED on an edge with run_en=0.
REQ-019 SHALL count tick_in only on edges where registered state is RUN; tick_in in PAUSED is discarded, and the prescaler holds its value.
REQ-020 SHALL keep an 8-bit prescaler 0..TICKS_PER_SEC-1; a counted tick_in at TICKS_PER_SEC-1 clears it and advances seconds, otherwise it increments.
REQ-021 SHALL make the seconds advance, sec_pulse and any resulting carries visible one cycle after the qualifying tick_in edge (registered outputs, latency 1).
REQ-022 SHALL wrap seconds 59->0 with minute carry, minutes 59->0 with hour carry, and hours 23->0 with day_rollover, all rippling in the same cycle.
REQ-023 SHALL drive set_ready = 1 only in PAUSED; set_valid while set_ready = 0 is ignored with no error.
REQ-024 SHALL, on accepted load with hours<=23, minutes<=59, seconds<=59, update all three outputs and clear the prescaler on that edge.
REQ-025 SHALL, on accepted load with any field out of range, leave time and prescaler unchanged and pulse set_error one cycle later.
REQ-026 SHALL accept a load on the edge where run_en rises (state still PAUSED); RUN begins the next cycle with the loaded time.
REQ-027 SHALL generate no sec_pulse, day_rollover or alarm_hit from a load.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, set state PAUSED, prescaler 0, hours/minutes/seconds 0, and set_error, sec_pulse, day_rollover, alarm_hit 0; set_ready = 1 after reset.
REQ-029 SHALL give reset priority over tick_in, set_valid and run_en on the same edge, including mid-count.

Configuration
REQ-030 SHALL, with TIME_OF_DAY_KEEPER_ALARM_EN defined, pulse alarm_hit one cycle with the advance that makes time equal alarm_hours:alarm_minutes:00 while alarm_arm=1.
REQ-031 SHALL, without TIME_OF_DAY_KEEPER_ALARM_EN, keep the alarm ports present, ignore the alarm inputs, and hold alarm_hit at 0.

Verification
REQ-032 SHALL cover reset, run_en=1, TICKS_PER_SEC=1, 60 tick_in pulses -> seconds 0..59 then 0, minutes=1, exactly 60 sec_pulse.
REQ-033 SHALL cover a load of 23:59:59 while PAUSED, then run with one tick -> 00:00:00 and a single day_rollover pulse.
REQ-034 SHALL cover a load of 12:60:00 while PAUSED -> set_error pulse, time unchanged at the previous value.
REQ-035 SHALL cover TICKS_PER_SEC=4, 3 ticks, pause, 5 ticks, resume, 1 tick -> seconds advance by exactly 1.
REQ-036 SHALL cover reset asserted at 07:30:15 with a concurrent tick_in -> 00:00:00, state PAUSED, no sec_pulse.
REQ-037 SHALL cover alarm build: arm at 06:00, load 05:59:59, one tick -> alarm_hit 1 cycle; non-alarm build -> alarm_hit stays 0.

Source files
------------

// File: rtl/time_of_day_keeper.sv
// Time-of-day keeper: tick prescaler, HH:MM:SS counter with wrap pulses, pausable load port.
// Optional alarm comparator enabled by defining TIME_OF_DAY_KEEPER_ALARM_EN.
module time_of_day_keeper #(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       run_en,
    input  logic       set_valid,
    input  logic [4:0] set_hours,
    input  logic [5:0] set_minutes,
    input  logic [5:0] set_seconds,
    output logic       set_ready,
    output logic       set_error,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       sec_pulse,
    output logic       day_rollover,
    input  logic       alarm_arm,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    output logic       alarm_hit
);

    typedef enum logic {
        PAUSED = 1'b0,
        RUN    = 1'b1
    } state_t;

    localparam logic [7:0] PRESCALE_MAX = 8'(TICKS_PER_SEC - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] prescaler;

    logic       count_tick;
    logic       advance;
    logic       sec_wrap;
    logic       min_wrap;
    logic       hr_wrap;
    logic [4:0] hours_next;
    logic [5:0] minutes_next;
    logic [5:0] seconds_next;
    logic       load_accept;
    logic       load_ok;
    logic       alarm_match;

    function automatic logic fields_in_range(input logic [4:0] h,
                                             input logic [5:0] m,
                                             input logic [5:0] s);
        return (h <= 5'd23) && (m <= 6'd59) && (s <= 6'd59);
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PAUSED;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: registered state simply follows run_en
    always_comb begin
        state_next = state;
        case (state)
            PAUSED:  if (run_en)  state_next = RUN;
            RUN:     if (!run_en) state_next = PAUSED;
            default: state_next = PAUSED;
        endcase
    end

    // Output logic: loads are only accepted while paused
    always_comb begin
        set_ready = 1'b0;
        case (state)
            PAUSED:  set_ready = 1'b1;
            RUN:     set_ready = 1'b0;
            default: set_ready = 1'b0;
        endcase
    end

    always_comb begin
        count_tick = (state == RUN) && tick_in;
        advance    = count_tick && (prescaler == PRESCALE_MAX);
        load_accept = set_valid && set_ready;
        load_ok     = fields_in_range(set_hours, set_minutes, set_seconds);
    end

    // Carry chain for a one-second advance; all wraps ripple in one cycle
    always_comb begin
        sec_wrap     = (seconds == 6'd59);
        min_wrap     = sec_wrap && (minutes == 6'd59);
        hr_wrap      = min_wrap && (hours == 5'd23);
        seconds_next = sec_wrap ? 6'd0 : seconds + 6'd1;
        minutes_next = minutes;
        hours_next   = hours;
        if (sec_wrap) begin
            minutes_next = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
        end
        if (min_wrap) begin
            hours_next = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
        end
    end

`ifdef TIME_OF_DAY_KEEPER_ALARM_EN
    always_comb begin
        alarm_match = alarm_arm && advance &&
                      (hours_next == alarm_hours) &&
                      (minutes_next == alarm_minutes) &&
                      (seconds_next == 6'd0);
    end
`else
    logic alarm_unused;
    assign alarm_unused = ^{alarm_arm, alarm_hours, alarm_minutes};
    assign alarm_match  = 1'b0;
`endif

    // Prescaler and time registers
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= 8'd0;
            hours     <= 5'd0;
            minutes   <= 6'd0;
            seconds   <= 6'd0;
        end else if (load_accept) begin
            if (load_ok) begin
                prescaler <= 8'd0;
                hours     <= set_hours;
                minutes   <= set_minutes;
                seconds   <= set_seconds;
            end
        end else if (count_tick) begin
            if (advance) begin
                prescaler <= 8'd0;
                hours     <= hours_next;
                minutes   <= minutes_next;
                seconds   <= seconds_next;
            end else begin
                prescaler <= prescaler + 8'd1;
            end
        end
    end

    // Single-cycle status pulses, registered alongside the time update
    always_ff @(posedge clk) begin
        if (reset) begin
            set_error    <= 1'b0;
            sec_pulse    <= 1'b0;
            day_rollover <= 1'b0;
            alarm_hit    <= 1'b0;
        end else begin
            set_error    <= load_accept && !load_ok;
            sec_pulse    <= advance;
            day_rollover <= advance && hr_wrap;
            alarm_hit    <= alarm_match;
        end
    end

endmodule

// File: tb/tb_time_of_day_keeper.sv
// Directed bench for time_of_day_keeper: one instance at 1 tick/s, one at 4 ticks/s.
module tb_time_of_day_keeper;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_in = 1'b0;
    logic       run_en = 1'b0;
    logic       set_valid = 1'b0;
    logic [4:0] set_hours = '0;
    logic [5:0] set_minutes = '0;
    logic [5:0] set_seconds = '0;
    logic       alarm_arm = 1'b0;
    logic [4:0] alarm_hours = '0;
    logic [5:0] alarm_minutes = '0;

    logic       set_ready, set_error, sec_pulse, day_rollover, alarm_hit;
    logic [4:0] hours;
    logic [5:0] minutes, seconds;

    logic       set_ready4, set_error4, sec_pulse4, day_rollover4, alarm_hit4;
    logic [4:0] hours4;
    logic [5:0] minutes4, seconds4;

    int checks = 0;
    int errors = 0;

    time_of_day_keeper #(.TICKS_PER_SEC(1)) dut (
        .clk(clk), .reset(reset), .tick_in(tick_in), .run_en(run_en),
        .set_valid(set_valid), .set_hours(set_hours), .set_minutes(set_minutes),
        .set_seconds(set_seconds), .set_ready(set_ready), .set_error(set_error),
        .hours(hours), .minutes(minutes), .seconds(seconds), .sec_pulse(sec_pulse),
        .day_rollover(day_rollover), .alarm_arm(alarm_arm), .alarm_hours(alarm_hours),
        .alarm_minutes(alarm_minutes), .alarm_hit(alarm_hit)
    );

    time_of_day_keeper #(.TICKS_PER_SEC(4)) dut4 (
        .clk(clk), .reset(reset), .tick_in(tick_in), .run_en(run_en),
        .set_valid(set_valid), .set_hours(set_hours), .set_minutes(set_minutes),
        .set_seconds(set_seconds), .set_ready(set_ready4), .set_error(set_error4),
        .hours(hours4), .minutes(minutes4), .seconds(seconds4), .sec_pulse(sec_pulse4),
        .day_rollover(day_rollover4), .alarm_arm(alarm_arm), .alarm_hours(alarm_hours),
        .alarm_minutes(alarm_minutes), .alarm_hit(alarm_hit4)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_once();
        tick_in = 1'b1;
        cycle();
        tick_in = 1'b0;
    endtask

    task automatic drive_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        set_valid   = 1'b1;
        set_hours   = h;
        set_minutes = m;
        set_seconds = s;
        cycle();
        set_valid = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        checks++;
        if ({hours, minutes, seconds} !== 17'd0) begin
            errors++;
            $display("FAIL reset_time got %0d:%0d:%0d want 0:0:0", hours, minutes, seconds);
        end
        checks++;
        if ({set_ready, set_error, sec_pulse, day_rollover, alarm_hit} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got %b want 10000",
                     {set_ready, set_error, sec_pulse, day_rollover, alarm_hit});
        end
        reset = 1'b0;
    endtask

    task automatic test_count60();
        int pulses = 0;
        apply_reset();
        run_en = 1'b1;
        cycle();
        checks++;
        if (set_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_ready got %b want 0", set_ready);
        end
        for (int i = 0; i < 60; i++) begin
            tick_once();
            if (sec_pulse === 1'b1) pulses++;
            checks++;
            if (seconds !== 6'((i + 1) % 60)) begin
                errors++;
                $display("FAIL count_sec step %0d got %0d want %0d", i, seconds, (i + 1) % 60);
            end
            cycle();
            if (sec_pulse === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 60) begin
            errors++;
            $display("FAIL count_pulses got %0d want 60", pulses);
        end
        checks++;
        if ({hours, minutes, seconds} !== {5'd0, 6'd1, 6'd0}) begin
            errors++;
            $display("FAIL count_final got %0d:%0d:%0d want 0:1:0", hours, minutes, seconds);
        end
    endtask

    task automatic test_day_rollover();
        int rolls = 0;
        run_en = 1'b0;
        cycle();
        drive_load(5'd23, 6'd59, 6'd59);
        checks++;
        if ({hours, minutes, seconds} !== {5'd23, 6'd59, 6'd59} || sec_pulse !== 1'b0
            || set_error !== 1'b0) begin
            errors++;
            $display("FAIL roll_load got %0d:%0d:%0d sp=%b err=%b want 23:59:59 sp=0 err=0",
                     hours, minutes, seconds, sec_pulse, set_error);
        end
        run_en = 1'b1;
        cycle();
        tick_once();
        if (day_rollover === 1'b1) rolls++;
        checks++;
        if ({hours, minutes, seconds} !== 17'd0) begin
            errors++;
            $display("FAIL roll_time got %0d:%0d:%0d want 0:0:0", hours, minutes, seconds);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (day_rollover === 1'b1) rolls++;
        end
        checks++;
        if (rolls != 1) begin
            errors++;
            $display("FAIL roll_pulses got %0d want 1", rolls);
        end
    endtask

    task automatic test_bad_load();
        run_en = 1'b0;
        cycle();
        drive_load(5'd1, 6'd2, 6'd3);
        drive_load(5'd12, 6'd60, 6'd0);
        checks++;
        if (set_error !== 1'b1) begin
            errors++;
            $display("FAIL bad_err got %b want 1", set_error);
        end
        checks++;
        if ({hours, minutes, seconds} !== {5'd1, 6'd2, 6'd3}) begin
            errors++;
            $display("FAIL bad_time got %0d:%0d:%0d want 1:2:3", hours, minutes, seconds);
        end
        cycle();
        checks++;
        if (set_error !== 1'b0) begin
            errors++;
            $display("FAIL bad_err_clear got %b want 0", set_error);
        end
        // Out-of-range load while running must be ignored silently
        run_en = 1'b1;
        cycle();
        drive_load(5'd30, 6'd0, 6'd0);
        checks++;
        if (set_error !== 1'b0 || {hours, minutes, seconds} !== {5'd1, 6'd2, 6'd3}) begin
            errors++;
            $display("FAIL run_load got err=%b %0d:%0d:%0d want err=0 1:2:3",
                     set_error, hours, minutes, seconds);
        end
    endtask

    task automatic test_load_on_run_rise();
        run_en = 1'b0;
        cycle();
        run_en = 1'b1;
        drive_load(5'd10, 6'd20, 6'd30);
        checks++;
        if ({hours, minutes, seconds} !== {5'd10, 6'd20, 6'd30} || set_ready !== 1'b0) begin
            errors++;
            $display("FAIL rise_load got %0d:%0d:%0d rdy=%b want 10:20:30 rdy=0",
                     hours, minutes, seconds, set_ready);
        end
        tick_once();
        checks++;
        if ({hours, minutes, seconds} !== {5'd10, 6'd20, 6'd31}) begin
            errors++;
            $display("FAIL rise_tick got %0d:%0d:%0d want 10:20:31", hours, minutes, seconds);
        end
    endtask

    task automatic test_prescaler();
        run_en = 1'b0;
        apply_reset();
        run_en = 1'b1;
        cycle();
        for (int i = 0; i < 3; i++) tick_once();
        checks++;
        if (seconds4 !== 6'd0 || sec_pulse4 !== 1'b0) begin
            errors++;
            $display("FAIL pre_three got sec=%0d sp=%b want sec=0 sp=0", seconds4, sec_pulse4);
        end
        run_en = 1'b0;
        cycle();
        for (int i = 0; i < 5; i++) tick_once();
        checks++;
        if (seconds4 !== 6'd0) begin
            errors++;
            $display("FAIL pre_paused got sec=%0d want 0", seconds4);
        end
        run_en = 1'b1;
        cycle();
        tick_once();
        checks++;
        if (seconds4 !== 6'd1 || sec_pulse4 !== 1'b1) begin
            errors++;
            $display("FAIL pre_resume got sec=%0d sp=%b want sec=1 sp=1", seconds4, sec_pulse4);
        end
    endtask

    task automatic test_reset_priority();
        run_en = 1'b0;
        cycle();
        drive_load(5'd7, 6'd30, 6'd15);
        run_en = 1'b1;
        cycle();
        tick_once();
        tick_once();
        checks++;
        if ({hours, minutes, seconds} !== {5'd7, 6'd30, 6'd17}) begin
            errors++;
            $display("FAIL prio_setup got %0d:%0d:%0d want 7:30:17", hours, minutes, seconds);
        end
        reset       = 1'b1;
        tick_in     = 1'b1;
        set_valid   = 1'b1;
        set_hours   = 5'd3;
        set_minutes = 6'd4;
        set_seconds = 6'd5;
        cycle();
        reset     = 1'b0;
        tick_in   = 1'b0;
        set_valid = 1'b0;
        checks++;
        if ({hours, minutes, seconds} !== 17'd0 || {hours4, minutes4, seconds4} !== 17'd0) begin
            errors++;
            $display("FAIL prio_time got %0d:%0d:%0d / %0d:%0d:%0d want 0:0:0",
                     hours, minutes, seconds, hours4, minutes4, seconds4);
        end
        checks++;
        if (set_ready !== 1'b1 || sec_pulse !== 1'b0 || sec_pulse4 !== 1'b0) begin
            errors++;
            $display("FAIL prio_flags got rdy=%b sp=%b sp4=%b want 1 0 0",
                     set_ready, sec_pulse, sec_pulse4);
        end
        run_en = 1'b0;
        cycle();
    endtask

    task automatic test_alarm();
        logic exp_hit;
`ifdef TIME_OF_DAY_KEEPER_ALARM_EN
        exp_hit = 1'b1;
`else
        exp_hit = 1'b0;
`endif
        run_en = 1'b0;
        apply_reset();
        alarm_arm     = 1'b1;
        alarm_hours   = 5'd6;
        alarm_minutes = 6'd0;
        drive_load(5'd6, 6'd0, 6'd0);
        checks++;
        if (alarm_hit !== 1'b0) begin
            errors++;
            $display("FAIL alarm_on_load got %b want 0", alarm_hit);
        end
        drive_load(5'd5, 6'd59, 6'd59);
        run_en = 1'b1;
        cycle();
        tick_once();
        checks++;
        if ({hours, minutes, seconds} !== {5'd6, 6'd0, 6'd0} || alarm_hit !== exp_hit) begin
            errors++;
            $display("FAIL alarm_hit got %0d:%0d:%0d hit=%b want 6:0:0 hit=%b",
                     hours, minutes, seconds, alarm_hit, exp_hit);
        end
        cycle();
        checks++;
        if (alarm_hit !== 1'b0) begin
            errors++;
            $display("FAIL alarm_clear got %b want 0", alarm_hit);
        end
        alarm_arm = 1'b0;
        run_en    = 1'b0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_count60();
        test_day_rollover();
        test_bad_load();
        test_load_on_run_rise();
        test_prescaler();
        test_reset_priority();
        test_alarm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
